// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin arbiter sharing one 8-bit 2:1 select path
// Two requesters, bounded hold under contention, registered select, grants and captured byte.
module mux_share_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic [7:0] y,
  output logic       y_valid
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [7:0]       y_q, y_d;
  logic             y_valid_q, y_valid_d;

  logic             owner;
  logic             own_req;
  logic             oth_req;

  assign owner   = (state_q == GRANT1);
  assign own_req = owner ? req1 : req0;
  assign oth_req = owner ? req0 : req1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    y_d       = y_q;
    y_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (own_req) begin
          y_d       = owner ? i1 : i0;
          y_valid_d = 1'b1;
        end
        // A dropped request hands off immediately; a held one rotates only after the hold limit.
        if (!own_req) begin
          if (oth_req) state_d = owner ? GRANT0 : GRANT1;
          else         state_d = IDLE;
        end else if (oth_req && (cnt_q == CNT_MAX)) begin
          state_d = owner ? GRANT0 : GRANT1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != IDLE) && (state_d != state_q)) begin
      cnt_d  = '0;
      last_d = (state_d == GRANT1);
      sel_d  = (state_d == GRANT1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      y_q       <= 8'h00;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt0    = (state_q == GRANT0);
  assign gnt1    = (state_q == GRANT1);
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb/tb_mux_share_arbiter.sv - scoreboard bench for mux_share_arbiter
// Runs MAX_HOLD=4 and MAX_HOLD=1 instances on shared stimulus against an ownership model.
module tb_mux_share_arbiter;

  logic       clk = 1'b0;
  logic       reset, req0, req1;
  logic [7:0] i0, i1;
  logic       gnt0_a, gnt1_a, sel_a, y_valid_a;
  logic       gnt0_b, gnt1_b, sel_b, y_valid_b;
  logic [7:0] y_a, y_b;

  always #5 clk = ~clk;

  mux_share_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .y(y_a), .y_valid(y_valid_a)
  );

  mux_share_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .y(y_b), .y_valid(y_valid_b)
  );

  // owner: -1 nobody, 0/1 requester; run: cycles the current owner has held the path
  typedef struct {
    int         owner;
    int         run;
    int         last;
    logic       sel;
    logic [7:0] y;
    logic       yv;
  } model_t;

  model_t ma, mb;
  model_t qa[$];
  model_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic model_t step(model_t m, bit rst, bit r0, bit r1,
                                  logic [7:0] d0, logic [7:0] d1, int mh);
    model_t n;
    int     nxt;
    bit     rk, ro;
    n = m;
    if (rst) begin
      n.owner = -1; n.run = 0; n.last = 1; n.sel = 1'b0; n.y = 8'h00; n.yv = 1'b0;
      return n;
    end
    rk = (m.owner == 0) ? r0 : r1;
    ro = (m.owner == 0) ? r1 : r0;
    n.yv = 1'b0;
    if (m.owner >= 0 && rk) begin
      n.y  = (m.owner == 0) ? d0 : d1;
      n.yv = 1'b1;
    end
    if (m.owner < 0) begin
      if (r0 && r1)  nxt = 1 - m.last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else if (!rk) begin
      nxt = ro ? 1 - m.owner : -1;
    end else if (ro && m.run >= mh) begin
      nxt = 1 - m.owner;
    end else begin
      nxt = m.owner;
    end
    if (nxt >= 0 && nxt != m.owner) begin
      n.run  = 1;
      n.last = nxt;
      n.sel  = (nxt == 1);
    end else if (nxt >= 0) begin
      n.run = m.run + 1;
    end
    n.owner = nxt;
    return n;
  endfunction

  task automatic cycle(bit rst, bit r0, bit r1, logic [7:0] d0, logic [7:0] d1);
    reset = rst; req0 = r0; req1 = r1; i0 = d0; i1 = d1;
    @(posedge clk);
    ma = step(ma, rst, r0, r1, d0, d1, 4);
    mb = step(mb, rst, r0, r1, d0, d1, 1);
    qa.push_back(ma);
    qb.push_back(mb);
    #1;
  endtask

  task automatic check(string name, model_t e, logic g0, logic g1, logic s,
                       logic [7:0] yy, logic yv);
    n_cmp++;
    if (g0 !== (e.owner == 0) || g1 !== (e.owner == 1) || s !== e.sel ||
        yy !== e.y || yv !== e.yv || (g0 && g1)) begin
      n_bad++;
      $display("FAIL %s t=%0t: got gnt0=%b gnt1=%b sel=%b y=%h yv=%b, want gnt0=%b gnt1=%b sel=%b y=%h yv=%b",
               name, $time, g0, g1, s, yy, yv, e.owner == 0, e.owner == 1, e.sel, e.y, e.yv);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) check("hold4", qa.pop_front(), gnt0_a, gnt1_a, sel_a, y_a, y_valid_a);
    if (qb.size() > 0) check("hold1", qb.pop_front(), gnt0_b, gnt1_b, sel_b, y_b, y_valid_b);
  end

  initial begin
    ma = '{-1, 0, 1, 1'b0, 8'h00, 1'b0};
    mb = ma;
    // single requester, unbounded ownership
    cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 8'hA5, 8'h00);
    // simultaneous requests right after reset: rotation every MAX_HOLD cycles
    cycle(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, 8'h11, 8'h22);
    for (int i = 0; i < 8 && ma.owner != 1; i++) cycle(0, 1, 1, 8'h11, 8'h22);
    // owner 1 drops while 0 waits: direct handoff
    cycle(0, 1, 0, 8'h11, 8'h22);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h33, 8'h22);
    // both drop to idle, then requester 1 alone
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h44, 8'h55);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h44, 8'h66);
    // reset mid-grant with counter at 2, then a tie goes to requester 0
    cycle(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00, 8'h77);
    cycle(1, 1, 1, 8'h00, 8'h77);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'h88, 8'h99);
    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), 8'($urandom));
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit 2:1 select path between two requesters.
- Drives the select line `sel` and the per-requester grants.
- Captures the selected requester's byte into a registered output with a valid flag.
- Sits between two byte producers (e.g. switch/counter sources) and a single downstream consumer such as a display or register stage.

Parameters:
MAX_HOLD, 4, max consecutive granted cycles for one requester while the other is waiting (>=1)
CNT_W, 3, width of the hold counter; must hold MAX_HOLD-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 wants the path
req1  input  1  requester 1 wants the path
i0  input  8  requester 0 data
i1  input  8  requester 1 data
gnt0  output  1  requester 0 owns path (registered)
gnt1  output  1  requester 1 owns path (registered)
sel  output  1  select: 0 = i0, 1 = i1 (registered)
y  output  8  registered selected data
y_valid  output  1  y holds data from a granted, requesting cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- Reset: state = IDLE; gnt0 = gnt1 = 0; sel = 0; y = 8'h00; y_valid = 0; hold counter = 0; last_grant = 1, so req0 wins the first tie.
- Reset mid-operation overrides everything on that edge. Any grant in progress drops the next cycle with no partial output.
- States: IDLE, GRANT0, GRANT1. gnt0 = (state == GRANT0), gnt1 = (state == GRANT1). gnt0 and gnt1 are never both 1.
- sel = 0 in GRANT0 and 1 in GRANT1. In IDLE, sel keeps its last value.
- IDLE transitions:
  - req0 & req1 -> grant the requester != last_grant.
  - Only reqk -> GRANTk.
  - Neither -> stay in IDLE.
  - Counter cleared on every entry to a GRANT state.
- GRANTk transitions (o = other requester):
  - reqk = 0 and reqo = 1 -> GRANTo directly, zero-bubble handoff.
  - reqk = 0 and reqo = 0 -> IDLE.
  - reqk = 1, reqo = 1, counter == MAX_HOLD-1 -> GRANTo (forced rotation).
  - reqk = 1 otherwise -> stay; counter increments, saturating at MAX_HOLD-1.
  - With reqo = 0, ownership is unbounded.
- last_grant updates to k on every entry into GRANTk.
- Grant latency: req sampled at edge N; gnt asserted after edge N; observable 1 cycle after req rises from IDLE.
- Data path, one cycle after grant:
  - On each edge where state == GRANTk and reqk = 1: y <= ik, y_valid <= 1.
  - Otherwise y_valid <= 0 and y holds its value.
  - Requesters must hold ik stable while reqk & gntk.
- A requester that deasserts req while granted loses the grant on the same edge. Its data for that cycle is not captured.

Test Plan:
1. Reset, then req0 = 1, i0 = 8'hA5, req1 = 0 -> gnt0 = 1 after 1 edge; y = 8'hA5, y_valid = 1 after 2 edges; sel = 0; grant holds indefinitely past 10 cycles.
2. From IDLE, req0 = req1 = 1 on the same edge after reset -> GRANT0 first. With both held: gnt0 for exactly 4 cycles, then gnt1 for 4, alternating; y follows i0 = 8'h11 / i1 = 8'h22 one cycle behind sel.
3. In GRANT1, req1 drops while req0 = 1 -> next cycle gnt0 = 1, sel = 0, no IDLE cycle; y_valid has no gap beyond the dropped cycle.
4. Both requesters drop -> IDLE, gnt0 = gnt1 = 0, y_valid = 0 next cycle, y and sel keep their last values. Then req1 alone -> gnt1 = 1.
5. Assert reset during GRANT1 with counter = 2 -> next cycle all outputs at reset values. Subsequent simultaneous req0 & req1 -> requester 0 granted.
6. MAX_HOLD = 1 override with both requesting -> grant alternates every cycle; gnt0 & gnt1 never both 1 (checked by assertion on every cycle).
